// File: rtl/mcu_port_arbiter.sv
// Arbitrates the cache's MCU-side memory port against one DMA port onto a single memory-controller port.
// Optional watchdog abort is compiled in when MCU_ARB_TIMEOUT_EN is defined.
module mcu_port_arbiter #(
  parameter int BURST   = 2,
  parameter int HOLDOFF = 2
`ifdef MCU_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic        MCU_CLK,
  input  logic        RST,
  output logic        cpu_access,
  input  logic        cpu_do_act,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        mc_do_act,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic        mc_ack,
  input  logic [31:0] mc_rdata,
  input  logic        mc_rvalid,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, HOLD} state_t;
  typedef enum logic {PORT_CPU, PORT_DMA} port_t;

  localparam logic [2:0] BurstLen = 3'(BURST);
  localparam logic [2:0] HoldLast = 3'(HOLDOFF - 1);

  state_t      state_q, state_d;
  port_t       owner_q, owner_d, last_q, last_d;
  logic        active_q;
  logic [2:0]  beat_q, beat_d, hold_q, hold_d;
  logic        mc_do_act_q, mc_do_act_d, mc_we_q, mc_we_d;
  logic [31:0] mc_addr_q, mc_addr_d, mc_wdata_q, mc_wdata_d;
  logic        rd_phase, beat_ok, cpu_go, abort;

`ifdef MCU_ARB_TIMEOUT_EN
  localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);
  logic [7:0] wdog_q, wdog_d;
  logic       err_q;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == IDLE)                           wdog_d = '0;
    else if (state_q == ISSUE || state_q == RDATA) wdog_d = wdog_q + 8'd1;
  end

  assign abort       = (state_q == ISSUE || state_q == RDATA) && (wdog_q == WdogLast);
  assign err_timeout = err_q;

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= abort;
    end
  end
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Beats are accepted from the ISSUE cycle onward for reads, capped at BURST so the counter never wraps.
  assign rd_phase = (state_q == RDATA) || (state_q == ISSUE && !mc_we_q);
  assign beat_ok  = rd_phase && mc_rvalid && (beat_q < BurstLen);

  // active_q keeps the parked permit low while RST is asserted and until the first clock after release.
  always_comb begin
    cpu_access = 1'b0;
    case (state_q)
      IDLE:         cpu_access = active_q && !(dma_req && last_q == PORT_CPU);
      ISSUE, RDATA: cpu_access = (owner_q == PORT_CPU);
      default:      cpu_access = 1'b0;
    endcase
  end

  assign cpu_go     = cpu_do_act && cpu_access;
  assign cpu_ack    = (state_q == ISSUE) && mc_ack && !abort && (owner_q == PORT_CPU);
  assign dma_ack    = (state_q == ISSUE) && mc_ack && !abort && (owner_q == PORT_DMA);
  assign cpu_rdata  = (rd_phase && owner_q == PORT_CPU) ? mc_rdata : '0;
  assign dma_rdata  = (rd_phase && owner_q == PORT_DMA) ? mc_rdata : '0;
  assign dma_rvalid = beat_ok && (owner_q == PORT_DMA);

  assign mc_do_act = mc_do_act_q;
  assign mc_we     = mc_we_q;
  assign mc_addr   = mc_addr_q;
  assign mc_wdata  = mc_wdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    beat_d      = beat_ok ? beat_q + 3'd1 : beat_q;
    hold_d      = (state_q == HOLD) ? hold_q + 3'd1 : '0;
    mc_do_act_d = mc_do_act_q;
    mc_we_d     = mc_we_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_go || dma_req) begin
          owner_d     = cpu_go ? PORT_CPU : PORT_DMA;
          mc_we_d     = cpu_go ? cpu_we    : dma_we;
          mc_addr_d   = cpu_go ? cpu_addr  : dma_addr;
          mc_wdata_d  = cpu_go ? cpu_wdata : dma_wdata;
          mc_do_act_d = 1'b1;
          beat_d      = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          mc_do_act_d = 1'b0;
          state_d     = HOLD;
        end else if (mc_ack) begin
          mc_do_act_d = 1'b0;
          state_d     = (mc_we_q || beat_d == BurstLen) ? HOLD : RDATA;
        end
      end
      RDATA: begin
        if (abort || beat_d == BurstLen) state_d = HOLD;
      end
      HOLD: begin
        if (hold_q == HoldLast) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      owner_q     <= PORT_CPU;
      last_q      <= PORT_CPU;
      active_q    <= 1'b0;
      beat_q      <= '0;
      hold_q      <= '0;
      mc_do_act_q <= 1'b0;
      mc_we_q     <= 1'b0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      active_q    <= 1'b1;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      mc_do_act_q <= mc_do_act_d;
      mc_we_q     <= mc_we_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
    end
  end

endmodule

// File: tb/tb_mcu_port_arbiter.sv
// Directed bench for mcu_port_arbiter; the cache is modelled as cpu_do_act = cpu_req & cpu_access.
`timescale 1ns/1ps
module tb_mcu_port_arbiter;

  logic        MCU_CLK = 1'b0;
  logic        RST;
  logic        cpu_access, cpu_do_act, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mc_do_act, mc_we, mc_ack, mc_rvalid, err_timeout;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;
  logic        cpu_req;

  int checks = 0;
  int errors = 0;

  assign cpu_do_act = cpu_req & cpu_access;

  always #5 MCU_CLK = ~MCU_CLK;

  mcu_port_arbiter #(
    .BURST  (2),
    .HOLDOFF(2)
`ifdef MCU_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .MCU_CLK    (MCU_CLK),
    .RST        (RST),
    .cpu_access (cpu_access),
    .cpu_do_act (cpu_do_act),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mc_do_act  (mc_do_act),
    .mc_we      (mc_we),
    .mc_addr    (mc_addr),
    .mc_wdata   (mc_wdata),
    .mc_ack     (mc_ack),
    .mc_rdata   (mc_rdata),
    .mc_rvalid  (mc_rvalid),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCU_CLK);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mc_ack = 1'b0; mc_rdata = '0; mc_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    clear_inputs();
    tick();
    RST = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    clear_inputs();
    #2;
    chk("rst_cpu_access", cpu_access, 1'b0);
    chk("rst_mc_do_act", mc_do_act, 1'b0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    chk("rst_acks", {cpu_ack, dma_ack, dma_rvalid}, 3'b000);
    chk("rst_err", err_timeout, 1'b0);
    tick();
    RST = 1'b1;
    tick();
    chk("idle_parked", cpu_access, 1'b1);

    // Test 1: CPU read, ack on 3rd ISSUE cycle, two beats, then 2-cycle hold-off
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000; #1;
    chk("t1_do_act", cpu_do_act, 1'b1);
    tick();
    chk("t1_mc_do_act", mc_do_act, 1'b1);
    chk("t1_mc_addr", mc_addr, 32'h0000_1000);
    chk("t1_mc_we", mc_we, 1'b0);
    chk("t1_no_early_ack", cpu_ack, 1'b0);
    tick();
    tick();
    mc_ack = 1'b1; #1;
    chk("t1_cpu_ack", cpu_ack, 1'b1);
    chk("t1_dma_ack", dma_ack, 1'b0);
    tick();
    mc_ack = 1'b0; mc_rvalid = 1'b1; mc_rdata = 32'hA5A5_A5A5; #1;
    chk("t1_beat0", cpu_rdata, 32'hA5A5_A5A5);
    chk("t1_dma_rdata0", dma_rdata, 32'h0);
    chk("t1_dma_rvalid", dma_rvalid, 1'b0);
    chk("t1_ack_gone", cpu_ack, 1'b0);
    chk("t1_mc_do_act_low", mc_do_act, 1'b0);
    tick();
    cpu_req = 1'b0; mc_rdata = 32'h5A5A_5A5A; #1;
    chk("t1_beat1", cpu_rdata, 32'h5A5A_5A5A);
    tick();
    mc_rvalid = 1'b0; mc_rdata = '0; #1;
    chk("t1_hold1_access", cpu_access, 1'b0);
    tick();
    chk("t1_hold2_access", cpu_access, 1'b0);
    tick();
    chk("t1_idle_access", cpu_access, 1'b1);

    // Test 2: simultaneous requests from reset; DMA first, held CPU write next
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'hCAFE_F00D;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0040; #1;
    chk("t2_access_blocked", cpu_access, 1'b0);
    chk("t2_cpu_gated", cpu_do_act, 1'b0);
    tick();
    chk("t2_dma_addr", mc_addr, 32'h0000_0040);
    chk("t2_dma_owner_access", cpu_access, 1'b0);
    mc_ack = 1'b1; #1;
    chk("t2_dma_ack", dma_ack, 1'b1);
    chk("t2_no_cpu_ack", cpu_ack, 1'b0);
    tick();
    mc_ack = 1'b0; dma_req = 1'b0; mc_rvalid = 1'b1; mc_rdata = 32'h1111_1111; #1;
    chk("t2_dma_rvalid", dma_rvalid, 1'b1);
    chk("t2_dma_rdata0", dma_rdata, 32'h1111_1111);
    chk("t2_cpu_rdata0", cpu_rdata, 32'h0);
    tick();
    mc_rdata = 32'h2222_2222; #1;
    chk("t2_dma_rdata1", dma_rdata, 32'h2222_2222);
    tick();
    mc_rvalid = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0020; dma_wdata = 32'hDEAD_BEEF; #1;
    chk("t2_hold_access", cpu_access, 1'b0);
    chk("t2_hold_rvalid", dma_rvalid, 1'b0);
    tick();
    chk("t2_hold_no_reissue", mc_do_act, 1'b0);
    tick();
    chk("t2_cpu_turn", cpu_access, 1'b1);
    tick();
    chk("t2_cpu_addr", mc_addr, 32'h0000_2000);
    chk("t2_cpu_we", mc_we, 1'b1);
    chk("t2_cpu_wdata", mc_wdata, 32'hCAFE_F00D);
    mc_ack = 1'b1; #1;
    chk("t2_cpu_ack", cpu_ack, 1'b1);
    chk("t2_no_dma_ack", dma_ack, 1'b0);
    tick();
    mc_ack = 1'b0; cpu_req = 1'b0; #1;
    chk("t2_wr_hold1", mc_do_act, 1'b0);
    tick();
    chk("t2_wr_hold2", mc_do_act, 1'b0);
    tick();
    chk("t2_dma_turn_block", cpu_access, 1'b0);
    tick();

    // Test 3: DMA write, ack one cycle after issue
    chk("t3_mc_we", mc_we, 1'b1);
    chk("t3_mc_addr", mc_addr, 32'h0000_0020);
    chk("t3_mc_wdata", mc_wdata, 32'hDEAD_BEEF);
    chk("t3_mc_do_act", mc_do_act, 1'b1);
    chk("t3_no_early_ack", dma_ack, 1'b0);
    tick();
    mc_ack = 1'b1; cpu_req = 1'b1; #1;
    chk("t3_dma_ack", dma_ack, 1'b1);
    chk("t3_no_cpu_ack", cpu_ack, 1'b0);
    chk("t3_cpu_blocked", cpu_access, 1'b0);
    tick();
    mc_ack = 1'b0; dma_req = 1'b0; #1;
    chk("t3_ack_one_cycle", dma_ack, 1'b0);
    chk("t3_mc_do_act_fell", mc_do_act, 1'b0);
    chk("t3_hold1_access", cpu_access, 1'b0);
    tick();
    chk("t3_hold2_no_grant", mc_do_act, 1'b0);
    chk("t3_hold2_access", cpu_access, 1'b0);
    tick();
    cpu_req = 1'b0; #1;
    chk("t3_idle_access", cpu_access, 1'b1);

    // Test 4: spurious controller strobes in IDLE, then a CPU read still needs two beats
    mc_ack = 1'b1; mc_rvalid = 1'b1; mc_rdata = 32'hFFFF_FFFF; #1;
    chk("t4_no_cpu_ack", cpu_ack, 1'b0);
    chk("t4_no_dma_ack", dma_ack, 1'b0);
    chk("t4_no_rdata", cpu_rdata, 32'h0);
    chk("t4_no_rvalid", dma_rvalid, 1'b0);
    tick();
    mc_ack = 1'b0; mc_rvalid = 1'b0; #1;
    chk("t4_still_idle", mc_do_act, 1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3000;
    tick();
    mc_ack = 1'b1; #1;
    chk("t4_cpu_ack", cpu_ack, 1'b1);
    tick();
    mc_ack = 1'b0; cpu_req = 1'b0; mc_rvalid = 1'b1; mc_rdata = 32'h0000_0001; #1;
    chk("t4_beat0", cpu_rdata, 32'h0000_0001);
    tick();
    mc_rdata = 32'h0000_0002; #1;
    chk("t4_one_beat_rdata", cpu_access, 1'b1);
    chk("t4_beat1", cpu_rdata, 32'h0000_0002);
    tick();
    mc_rvalid = 1'b0; #1;
    chk("t4_hold", cpu_access, 1'b0);
    tick();
    tick();

    // Both beats arrive by the ack cycle: ISSUE goes straight to HOLD
    cpu_req = 1'b1; cpu_addr = 32'h0000_3100;
    tick();
    mc_rvalid = 1'b1; mc_rdata = 32'h0000_0003; #1;
    chk("t4b_early_beat", cpu_rdata, 32'h0000_0003);
    chk("t4b_no_ack_yet", cpu_ack, 1'b0);
    tick();
    mc_ack = 1'b1; mc_rdata = 32'h0000_0004; #1;
    chk("t4b_ack", cpu_ack, 1'b1);
    chk("t4b_ack_beat", cpu_rdata, 32'h0000_0004);
    tick();
    mc_ack = 1'b0; mc_rvalid = 1'b0; cpu_req = 1'b0; #1;
    chk("t4b_direct_hold", cpu_access, 1'b0);
    chk("t4b_mc_do_act", mc_do_act, 1'b0);
    tick();
    tick();
    chk("t4b_idle", cpu_access, 1'b1);

    // Test 5: reset mid-RDATA after one beat
    cpu_req = 1'b1; cpu_addr = 32'h0000_4000;
    tick();
    mc_ack = 1'b1;
    tick();
    mc_ack = 1'b0; cpu_req = 1'b0; mc_rvalid = 1'b1; mc_rdata = 32'h0000_0055;
    tick();
    mc_rvalid = 1'b0; mc_rdata = 32'h7777_7777; #1;
    chk("t5_pre_rdata", cpu_rdata, 32'h7777_7777);
    RST = 1'b0; #1;
    chk("t5_rst_access", cpu_access, 1'b0);
    chk("t5_rst_mc_addr", mc_addr, 32'h0);
    chk("t5_rst_rdata", cpu_rdata, 32'h0);
    chk("t5_rst_mc_do_act", mc_do_act, 1'b0);
    tick();
    RST = 1'b1;
    tick();
    chk("t5_post_access", cpu_access, 1'b1);
    cpu_req = 1'b1; cpu_addr = 32'h0000_5000;
    tick();
    chk("t5_mc_addr", mc_addr, 32'h0000_5000);
    mc_ack = 1'b1; #1;
    chk("t5_cpu_ack", cpu_ack, 1'b1);
    tick();
    mc_ack = 1'b0; cpu_req = 1'b0; mc_rvalid = 1'b1;
    tick();
    #1;
    chk("t5_count_from_zero", cpu_access, 1'b1);
    tick();
    mc_rvalid = 1'b0; #1;
    chk("t5_hold", cpu_access, 1'b0);
    tick();
    tick();

`ifdef MCU_ARB_TIMEOUT_EN
    // Test 6: controller never acks; watchdog aborts after 8 ISSUE cycles
    cpu_req = 1'b1; cpu_addr = 32'h0000_6000;
    tick();
    repeat (7) tick();
    chk("t6_pre_abort_act", mc_do_act, 1'b1);
    chk("t6_pre_abort_err", err_timeout, 1'b0);
    tick();
    chk("t6_abort_act", mc_do_act, 1'b0);
    chk("t6_err_pulse", err_timeout, 1'b1);
    chk("t6_no_ack", cpu_ack, 1'b0);
    chk("t6_hold_access", cpu_access, 1'b0);
    cpu_req = 1'b0;
    tick();
    chk("t6_err_one_cycle", err_timeout, 1'b0);
    tick();
    chk("t6_idle", cpu_access, 1'b1);
`else
    chk("err_tied_low", err_timeout, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
